// File: rtl/muxn_bist.sv
// muxn_bist: registered N-way (N = 2**SELW), WIDTH-bit multiplexer with a
// built-in self-test sequencer.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous, active-high reset
//   din         N lanes, lane i = din[i*WIDTH +: WIDTH]
//   sel         lane select (normal mode)
//   en          output register enable (normal mode)
//   fault_inj   inverts dout bit 0 at the register input (all modes)
//   bist_start  starts a self-test when sampled high in IDLE or DONE
//   dout        registered mux output
//   bist_busy   high while the self-test runs (RUN, DRAIN)
//   bist_done   high once the self-test finished (DONE)
//   bist_pass   high in DONE when no mismatch was seen
//   err_cnt     mismatch count, saturating at 255
//
// The self-test sweeps 2N steps. Step k selects lane k>>1 and drives it with
// the alternating pattern A (polarity k[0] picks A or ~A); every other lane
// carries the opposite pattern, so a wrong select always shows up as a
// mismatch. Each registered result is compared one cycle later against the
// expected value captured alongside it.
module muxn_bist #(
   parameter int WIDTH = 4,
   parameter int SELW  = 2
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [(2**SELW)*WIDTH-1:0]  din,
   input  logic [SELW-1:0]             sel,
   input  logic                        en,
   input  logic                        fault_inj,
   input  logic                        bist_start,
   output logic [WIDTH-1:0]            dout,
   output logic                        bist_busy,
   output logic                        bist_done,
   output logic                        bist_pass,
   output logic [7:0]                  err_cnt
);

   localparam int N = 2**SELW;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t                 state, state_nxt;
   logic [SELW:0]          step;
   logic [WIDTH-1:0]       exp_q;

   logic [WIDTH-1:0]       pat_a;
   logic [SELW-1:0]        step_lane;
   logic [WIDTH-1:0]       step_pat;
   logic [N*WIDTH-1:0]     stim;
   logic [N*WIDTH-1:0]     mux_src;
   logic [SELW-1:0]        mux_sel;
   logic [WIDTH-1:0]       mux_out;
   logic [WIDTH-1:0]       d_next;
   logic                   last_step;
   logic                   mismatch;
   logic                   normal;

   // Alternating pattern 1010..., LSB = 0
   for (genvar g = 0; g < WIDTH; g++) begin : g_pat
      assign pat_a[g] = 1'(g % 2);
   end

   assign step_lane = step[SELW:1];
   assign step_pat  = step[0] ? ~pat_a : pat_a;

   for (genvar l = 0; l < N; l++) begin : g_stim
      assign stim[l*WIDTH +: WIDTH] = (step_lane == SELW'(l)) ? step_pat : ~step_pat;
   end

   // One shared mux: internal stimulus while running, external lanes otherwise
   assign mux_src   = (state == RUN) ? stim : din;
   assign mux_sel   = (state == RUN) ? step_lane : sel;
   assign mux_out   = mux_src[mux_sel*WIDTH +: WIDTH];
   assign d_next    = mux_out ^ WIDTH'(fault_inj);

   assign normal    = (state == IDLE) || (state == DONE);
   assign last_step = (step == (SELW+1)'(2*N-1));
   assign mismatch  = (dout != exp_q);

   assign bist_busy = (state == RUN) || (state == DRAIN);
   assign bist_done = (state == DONE);
   assign bist_pass = (state == DONE) && (err_cnt == 8'd0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE: if (bist_start) state_nxt = RUN;
         RUN:        if (last_step)  state_nxt = DRAIN;
         DRAIN:                      state_nxt = DONE;
         default:                    state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dout    <= '0;
         exp_q   <= '0;
         step    <= '0;
         err_cnt <= '0;
      end else if (normal) begin
         // A start takes priority over en: dout is left alone here and
         // step 0 is loaded on the first RUN edge.
         if (bist_start) begin
            step    <= '0;
            err_cnt <= '0;
         end else if (en) begin
            dout <= d_next;
         end
      end else if (state == RUN) begin
         dout  <= d_next;
         exp_q <= step_pat;
         step  <= step + 1'b1;
         // On step 0 dout still holds pre-test data; nothing to compare yet
         if (step != '0 && mismatch && err_cnt != 8'hFF)
            err_cnt <= err_cnt + 8'd1;
      end else begin
         // DRAIN: compare the final step
         if (mismatch && err_cnt != 8'hFF)
            err_cnt <= err_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_muxn_bist.sv
// tb_muxn_bist: randomized and directed self-checking bench for muxn_bist.
// A behavioural model tracks the expected dout, the BIST progress as a plain
// cycle index, and the error count as the number of self-test steps that
// were loaded while fault_inj was high.
module tb_muxn_bist;

   localparam int W = 4;
   localparam int S = 2;
   localparam int N = 2**S;

   logic            clk = 1'b0;
   logic            reset;
   logic [N*W-1:0]  din;
   logic [S-1:0]    sel;
   logic            en, fault_inj, bist_start;
   logic [W-1:0]    dout;
   logic            bist_busy, bist_done, bist_pass;
   logic [7:0]      err_cnt;

   int n_chk  = 0;
   int n_fail = 0;

   // model state
   int          m_phase;   // -1: normal mode, 0..2N: BIST cycle index
   bit          m_done;
   logic [W-1:0] m_dout;
   int          m_err;

   muxn_bist #(.WIDTH(W), .SELW(S)) dut (
      .clk(clk), .reset(reset), .din(din), .sel(sel), .en(en),
      .fault_inj(fault_inj), .bist_start(bist_start), .dout(dout),
      .bist_busy(bist_busy), .bist_done(bist_done), .bist_pass(bist_pass),
      .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] pat(input int k);
      logic [W-1:0] a;
      for (int i = 0; i < W; i++) a[i] = (i % 2 == 1);
      return (k % 2 == 1) ? ~a : a;
   endfunction

   function automatic logic [W-1:0] lane(input logic [N*W-1:0] d, input int s);
      return d[s*W +: W];
   endfunction

   function automatic logic [W-1:0] fbit(input logic f);
      logic [W-1:0] v;
      v = '0;
      v[0] = f;
      return v;
   endfunction

   // advance the model by one edge using the currently driven inputs,
   // let the edge happen, then compare
   task automatic tick();
      if (reset) begin
         m_phase = -1; m_done = 0; m_dout = '0; m_err = 0;
      end else if (m_phase < 0) begin
         if (bist_start) begin
            m_phase = 0; m_done = 0; m_err = 0;
         end else if (en) begin
            m_dout = lane(din, int'(sel)) ^ fbit(fault_inj);
         end
      end else if (m_phase < 2*N) begin
         m_dout = pat(m_phase) ^ fbit(fault_inj);
         if (fault_inj && m_err < 255) m_err++;
         m_phase++;
      end else begin
         m_phase = -1; m_done = 1;
      end
      @(posedge clk); #1;
      chk("dout", 32'(dout), 32'(m_dout));
      chk("busy", 32'(bist_busy), 32'(m_phase >= 0));
      chk("done", 32'(bist_done), 32'(m_done));
      chk("pass", 32'(bist_pass), 32'(m_done && m_err == 0));
      if (m_phase < 0) chk("err_cnt", 32'(err_cnt), 32'(m_err));
   endtask

   // fmode: 0 no fault, 1 fault every cycle, 2 random fault
   task automatic run_bist(input int fmode);
      int cnt;
      cnt = 0;
      bist_start = 1'b1;
      tick();
      bist_start = 1'b0;
      while (bist_busy && cnt < 50) begin
         cnt++;
         fault_inj = (fmode == 1) ? 1'b1 : (fmode == 2) ? 1'($urandom_range(0, 3) == 0) : 1'b0;
         tick();
      end
      fault_inj = 1'b0;
      chk("busy_len", 32'(cnt), 32'(2*N+1));
      chk("done_after", 32'(bist_done), 32'd1);
   endtask

   initial begin
      reset = 1'b1; din = '0; sel = '0; en = 1'b0; fault_inj = 1'b0; bist_start = 1'b0;
      m_phase = -1; m_done = 0; m_dout = '0; m_err = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_dout", 32'(dout), 32'd0);
      chk("rst_busy", 32'(bist_busy), 32'd0);
      chk("rst_done", 32'(bist_done), 32'd0);
      chk("rst_pass", 32'(bist_pass), 32'd0);
      chk("rst_err", 32'(err_cnt), 32'd0);
      reset = 1'b0;

      // normal mode sweep
      en = 1'b1; din = 16'hFC3A;
      for (int s = 0; s < N; s++) begin
         sel = S'(s);
         tick();
      end
      chk("sweep_last", 32'(dout), 32'hF);

      // hold with en=0
      en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         din = N*W'($urandom); sel = S'($urandom);
         tick();
      end
      chk("hold", 32'(dout), 32'hF);

      // clean BIST
      run_bist(0);
      chk("clean_pass", 32'(bist_pass), 32'd1);
      chk("clean_err", 32'(err_cnt), 32'd0);
      chk("clean_dout", 32'(dout), 32'h5);

      // faulted BIST
      run_bist(1);
      chk("fault_err", 32'(err_cnt), 32'd8);
      chk("fault_pass", 32'(bist_pass), 32'd0);

      // reset during RUN step 4
      bist_start = 1'b1;
      tick();
      bist_start = 1'b0;
      repeat (4) tick();
      reset = 1'b1;
      #2;
      chk("abort_dout", 32'(dout), 32'd0);
      chk("abort_busy", 32'(bist_busy), 32'd0);
      chk("abort_err", 32'(err_cnt), 32'd0);
      tick();
      reset = 1'b0;
      run_bist(0);
      chk("after_abort_pass", 32'(bist_pass), 32'd1);

      // restart from DONE with en=1: din must be ignored
      run_bist(1);
      en = 1'b1; din = 16'h1234; sel = 2'd1;
      run_bist(0);
      en = 1'b0;
      chk("restart_pass", 32'(bist_pass), 32'd1);
      chk("restart_err", 32'(err_cnt), 32'd0);

      // random traffic
      for (int i = 0; i < 400; i++) begin
         din        = N*W'($urandom);
         sel        = S'($urandom);
         en         = 1'($urandom);
         fault_inj  = 1'($urandom_range(0, 4) == 0);
         bist_start = 1'($urandom_range(0, 15) == 0);
         reset      = 1'($urandom_range(0, 150) == 0);
         tick();
      end
      reset = 1'b0; bist_start = 1'b0; fault_inj = 1'b0;
      tick();
      run_bist(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
